// File: rtl/led_palette_fader.sv
// Palette controller: holds current/target/step per LED channel and ramps every
// current value toward its target once per fade tick, one channel per cycle.
module led_palette_fader #(
    parameter int parm_color_led_count          = 4,
    parameter int parm_basic_led_count          = 4,
    parameter int parm_FCLK                     = 40_000_000,
    parameter int parm_step_period_milliseconds = 10
) (
    input  logic                              i_clk,
    input  logic                              i_srst,
    input  logic                              i_cmd_valid,
    output logic                              o_cmd_ready,
    input  logic                              i_cmd_is_basic,
    input  logic [7:0]                        i_cmd_index,
    input  logic [7:0]                        i_cmd_red,
    input  logic [7:0]                        i_cmd_green,
    input  logic [7:0]                        i_cmd_blue,
    input  logic [7:0]                        i_cmd_step,
    output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
    output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
    output logic                              o_busy,
    output logic                              o_fade_done,
    output logic                              o_cmd_error,
    output logic                              o_dbg_state
);

    localparam int C    = parm_color_led_count;
    localparam int B    = parm_basic_led_count;
    localparam int NCH  = 3 * C + B;
    localparam int TICK = parm_FCLK / 1000 * parm_step_period_milliseconds;
    localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int KW   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Command handshake: a command transfers on a rising edge where
    // i_cmd_valid and o_cmd_ready are both high; o_cmd_ready is high only in IDLE.

    state_t          state_q;
    logic [TW-1:0]   tick_cnt_q;
    logic            pend_q;
    logic [KW-1:0]   scan_k_q;
    logic            changed_q;
    logic            ready_q;
    logic            busy_q;
    logic            fade_done_q;
    logic            err_q;

    logic [7:0]      cur_q  [NCH];
    logic [7:0]      tgt_q  [NCH];
    logic [7:0]      step_q [NCH];
    logic [7:0]      cur_d  [NCH];
    logic [7:0]      tgt_d  [NCH];
    logic [7:0]      step_d [NCH];

    logic            tick;
    logic            hs;
    logic            idx_ok;
    logic            scan_last;
    logic            scan_chg;
    logic            busy_d;
    logic [7:0]      scan_val;
    logic [7:0]      cmd_val;

    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt,
                                        input logic [7:0] stp);
        logic [8:0] sum;
        sum = {1'b0, cur} + {1'b0, stp};
        if (cur < tgt)
            return (sum >= {1'b0, tgt}) ? tgt : sum[7:0];
        else if (cur > tgt)
            return ((cur - tgt) <= stp) ? tgt : (cur - stp);
        else
            return cur;
    endfunction

    assign tick      = (tick_cnt_q == '0);
    assign hs        = i_cmd_valid && ready_q;
    assign idx_ok    = i_cmd_is_basic ? (int'(i_cmd_index) < B) : (int'(i_cmd_index) < C);
    assign scan_last = (state_q == ST_SCAN) && (scan_k_q == KW'(NCH - 1));

    always_comb begin
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        scan_chg = 1'b0;
        scan_val = cur_q[scan_k_q];
        cmd_val  = i_cmd_red;
        if (state_q == ST_SCAN) begin
            scan_val         = ramp(cur_q[scan_k_q], tgt_q[scan_k_q], step_q[scan_k_q]);
            scan_chg         = (scan_val != cur_q[scan_k_q]);
            cur_d[scan_k_q]  = scan_val;
        end
        // Channel layout: red 0..C-1, green C..2C-1, blue 2C..3C-1, basic 3C..NCH-1.
        if (hs && idx_ok) begin
            if (i_cmd_is_basic) begin
                for (int n = 0; n < B; n++) begin
                    if (int'(i_cmd_index) == n) begin
                        tgt_d[3*C+n]  = i_cmd_red;
                        step_d[3*C+n] = i_cmd_step;
                        if (i_cmd_step == 8'd0) cur_d[3*C+n] = i_cmd_red;
                    end
                end
            end else begin
                for (int n = 0; n < C; n++) begin
                    if (int'(i_cmd_index) == n) begin
                        for (int g = 0; g < 3; g++) begin
                            cmd_val = (g == 0) ? i_cmd_red : ((g == 1) ? i_cmd_green : i_cmd_blue);
                            tgt_d[g*C+n]  = cmd_val;
                            step_d[g*C+n] = i_cmd_step;
                            if (i_cmd_step == 8'd0) cur_d[g*C+n] = cmd_val;
                        end
                    end
                end
            end
        end
        busy_d = 1'b0;
        for (int i = 0; i < NCH; i++) busy_d = busy_d | (cur_d[i] != tgt_d[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= TW'(TICK - 1);
            pend_q      <= 1'b0;
            scan_k_q    <= '0;
            changed_q   <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            fade_done_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i]  <= 8'd0;
                tgt_q[i]  <= 8'd0;
                step_q[i] <= 8'd0;
            end
        end else begin
            tick_cnt_q  <= tick ? TW'(TICK - 1) : (tick_cnt_q - 1'b1);
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            err_q       <= hs && !idx_ok;
            fade_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick || pend_q) begin
                        state_q   <= ST_SCAN;
                        scan_k_q  <= '0;
                        pend_q    <= 1'b0;
                        changed_q <= 1'b0;
                        ready_q   <= 1'b0;
                    end else begin
                        ready_q   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    changed_q <= changed_q | scan_chg;
                    if (tick) pend_q <= 1'b1;
                    if (scan_last) begin
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                        fade_done_q <= (changed_q | scan_chg) && !busy_d;
                    end else begin
                        scan_k_q    <= scan_k_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_color_led_red_value   = '0;
        o_color_led_green_value = '0;
        o_color_led_blue_value  = '0;
        o_basic_led_lumin_value = '0;
        for (int n = 0; n < C; n++) begin
            o_color_led_red_value[8*n +: 8]   = cur_q[n];
            o_color_led_green_value[8*n +: 8] = cur_q[C+n];
            o_color_led_blue_value[8*n +: 8]  = cur_q[2*C+n];
        end
        for (int n = 0; n < B; n++) o_basic_led_lumin_value[8*n +: 8] = cur_q[3*C+n];
    end

    assign o_cmd_ready = ready_q;
    assign o_busy      = busy_q;
    assign o_fade_done = fade_done_q;
    assign o_cmd_error = err_q;
    assign o_dbg_state = (state_q == ST_SCAN);

endmodule

// File: tb/tb_led_palette_fader.sv
// Directed bench for led_palette_fader with a 100-cycle fade tick (C=4, B=4).
module tb_led_palette_fader;

    localparam int C = 4;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           srst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_is_basic;
    logic [7:0]     cmd_index;
    logic [7:0]     cmd_red;
    logic [7:0]     cmd_green;
    logic [7:0]     cmd_blue;
    logic [7:0]     cmd_step;
    logic [8*C-1:0] red_bus;
    logic [8*C-1:0] green_bus;
    logic [8*C-1:0] blue_bus;
    logic [8*B-1:0] lumin_bus;
    logic           busy;
    logic           fade_done;
    logic           cmd_error;
    logic           dbg_state;

    int checks   = 0;
    int failures = 0;
    int lowcnt;

    always #5 clk = ~clk;

    led_palette_fader #(
        .parm_color_led_count         (C),
        .parm_basic_led_count         (B),
        .parm_FCLK                    (100_000),
        .parm_step_period_milliseconds(1)
    ) dut (
        .i_clk                  (clk),
        .i_srst                 (srst),
        .i_cmd_valid            (cmd_valid),
        .o_cmd_ready            (cmd_ready),
        .i_cmd_is_basic         (cmd_is_basic),
        .i_cmd_index            (cmd_index),
        .i_cmd_red              (cmd_red),
        .i_cmd_green            (cmd_green),
        .i_cmd_blue             (cmd_blue),
        .i_cmd_step             (cmd_step),
        .o_color_led_red_value  (red_bus),
        .o_color_led_green_value(green_bus),
        .o_color_led_blue_value (blue_bus),
        .o_basic_led_lumin_value(lumin_bus),
        .o_busy                 (busy),
        .o_fade_done            (fade_done),
        .o_cmd_error            (cmd_error),
        .o_dbg_state            (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic level, input int budget, input string tag);
        int n;
        n = 0;
        while (cmd_ready !== level && n < budget) begin
            step();
            n++;
        end
        if (cmd_ready !== level) check(tag, 32'(cmd_ready), 32'(level));
    endtask

    task automatic send(input logic is_basic, input logic [7:0] idx, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b, input logic [7:0] st);
        wait_ready(1'b1, 200, "send_wait_ready");
        cmd_is_basic = is_basic;
        cmd_index    = idx;
        cmd_red      = r;
        cmd_green    = g;
        cmd_blue     = b;
        cmd_step     = st;
        cmd_valid    = 1'b1;
        step();
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_scan();
        wait_ready(1'b0, 150, "scan_start_timeout");
        wait_ready(1'b1, 40, "scan_end_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst = 1'b1; cmd_valid = 1'b0; cmd_is_basic = 1'b0; cmd_index = 8'd0;
        cmd_red = 8'd0; cmd_green = 8'd0; cmd_blue = 8'd0; cmd_step = 8'd0;
        for (int i = 0; i < 5; i++) step();
        check("rst_red", red_bus, 32'h0);
        check("rst_lumin", lumin_bus, 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        srst = 1'b0;

        // First tick: SCAN entered on the 100th edge after release.
        step();
        check("ready_after_rst", 32'(cmd_ready), 32'h1);
        check("idle_after_rst", 32'(dbg_state), 32'h0);
        for (int i = 0; i < 98; i++) step();
        check("ready_before_tick", 32'(cmd_ready), 32'h1);
        step();
        check("ready_at_first_scan", 32'(cmd_ready), 32'h0);
        check("scan_state", 32'(dbg_state), 32'h1);

        send(1'b0, 8'd2, 8'h12, 8'h34, 8'h56, 8'd0);
        check("imm_red", red_bus, 32'h0012_0000);
        check("imm_green", green_bus, 32'h0034_0000);
        check("imm_blue", blue_bus, 32'h0056_0000);
        check("imm_busy", 32'(busy), 32'h0);

        send(1'b0, 8'd0, 8'hFF, 8'h00, 8'h00, 8'd64);
        check("up_busy_start", 32'(busy), 32'h1);
        check("up_red_start", red_bus, 32'h0012_0000);
        wait_ready(1'b0, 150, "up_scan1_start");
        check("up_red_tick_plus1", 32'(red_bus[7:0]), 32'd0);
        step();
        check("up_red_tick_plus2", 32'(red_bus[7:0]), 32'd64);
        wait_ready(1'b1, 40, "up_scan1_end");
        check("up_busy1", 32'(busy), 32'h1);
        check("up_done1", 32'(fade_done), 32'h0);
        wait_scan();
        check("up_red2", 32'(red_bus[7:0]), 32'd128);
        check("up_done2", 32'(fade_done), 32'h0);
        wait_scan();
        check("up_red3", 32'(red_bus[7:0]), 32'd192);
        check("up_busy3", 32'(busy), 32'h1);
        check("up_done3", 32'(fade_done), 32'h0);
        wait_scan();
        check("up_red4", 32'(red_bus[7:0]), 32'd255);
        check("up_busy4", 32'(busy), 32'h0);
        check("up_done4", 32'(fade_done), 32'h1);
        step();
        check("up_done_pulse_end", 32'(fade_done), 32'h0);

        send(1'b1, 8'd3, 8'd200, 8'h00, 8'h00, 8'd0);
        check("dn_set", lumin_bus, 32'hC800_0000);
        check("dn_set_busy", 32'(busy), 32'h0);
        send(1'b1, 8'd3, 8'd10, 8'h00, 8'h00, 8'd250);
        check("dn_busy_start", 32'(busy), 32'h1);
        check("dn_hold", lumin_bus, 32'hC800_0000);
        wait_scan();
        check("dn_lumin", lumin_bus, 32'h0A00_0000);
        check("dn_done", 32'(fade_done), 32'h1);
        check("dn_busy_end", 32'(busy), 32'h0);

        send(1'b0, 8'd4, 8'hAA, 8'hBB, 8'hCC, 8'd0);
        check("oor_err", 32'(cmd_error), 32'h1);
        check("oor_red", red_bus, 32'h0012_00FF);
        check("oor_green", green_bus, 32'h0034_0000);
        check("oor_blue", blue_bus, 32'h0056_0000);
        step();
        check("oor_err_pulse_end", 32'(cmd_error), 32'h0);
        send(1'b1, 8'd4, 8'h55, 8'h00, 8'h00, 8'd0);
        check("oor_basic_err", 32'(cmd_error), 32'h1);
        check("oor_basic_lumin", lumin_bus, 32'h0A00_0000);
        send(1'b0, 8'd1, 8'h00, 8'h00, 8'h00, 8'd0);
        check("ok_no_err", 32'(cmd_error), 32'h0);

        // Command presented while a scan is running waits out the full scan.
        wait_ready(1'b0, 150, "bp_scan_start");
        cmd_is_basic = 1'b0; cmd_index = 8'd1; cmd_red = 8'h77;
        cmd_green = 8'h88; cmd_blue = 8'h99; cmd_step = 8'd0; cmd_valid = 1'b1;
        lowcnt = 1;
        while (cmd_ready === 1'b0 && lowcnt < 40) begin
            step();
            if (cmd_ready === 1'b0) lowcnt++;
        end
        check("bp_low_cycles", 32'(lowcnt), 32'd16);
        check("bp_not_yet", red_bus, 32'h0012_00FF);
        step();
        cmd_valid = 1'b0;
        check("bp_red", red_bus, 32'h0012_77FF);
        check("bp_green", green_bus, 32'h0034_8800);
        check("bp_blue", blue_bus, 32'h0056_9900);

        send(1'b0, 8'd3, 8'h00, 8'h00, 8'd200, 8'd1);
        check("mid_busy", 32'(busy), 32'h1);
        wait_ready(1'b0, 150, "mid_scan_start");
        for (int i = 0; i < 3; i++) step();
        srst = 1'b1;
        step();
        check("mid_rst_red", red_bus, 32'h0);
        check("mid_rst_green", green_bus, 32'h0);
        check("mid_rst_blue", blue_bus, 32'h0);
        check("mid_rst_lumin", lumin_bus, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ready", 32'(cmd_ready), 32'h0);
        check("mid_rst_state", 32'(dbg_state), 32'h0);
        srst = 1'b0;
        step();
        check("mid_rst_ready_back", 32'(cmd_ready), 32'h1);
        check("mid_rst_blue_after", blue_bus, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_palette_fader.md
# led_palette_fader

Command-driven palette controller that produces the packed 8-bit color and basic luminance value buses consumed by `led_pwm_driver`. It holds a current value and a target value for every filament channel. It ramps each current value toward its target by a per-channel step once per fade tick, so LEDs fade smoothly instead of jumping. It sits between the application FSM (command producer) and the PWM driver, in the same clock domain.

## Interface
- `parm_color_led_count`, 4, number of RGB LEDs (each has 3 channels)
- `parm_basic_led_count`, 4, number of single-filament LEDs
- `parm_FCLK`, 40_000_000, clock frequency in Hz
- `parm_step_period_milliseconds`, 10, fade tick period in ms
- Derived: `C = parm_color_led_count`, `B = parm_basic_led_count`, `NCH = 3*C + B`, `TICK = parm_FCLK/1000*parm_step_period_milliseconds` cycles

Ports:
- `i_clk`  in  1  system clock; the block has one clock
- `i_srst`  in  1  reset; synchronous and active-high
- `i_cmd_valid`  in  1  command valid
- `o_cmd_ready`  out  1  command ready
- `i_cmd_is_basic`  in  1  1 selects a basic LED, 0 selects a color LED
- `i_cmd_index`  in  8  LED index within the selected group
- `i_cmd_red`, `i_cmd_green`, `i_cmd_blue`  in  8 each  target values; a basic LED uses only `i_cmd_red`
- `i_cmd_step`  in  8  fade step per tick; 0 means an immediate set
- `o_color_led_red_value`, `o_color_led_green_value`, `o_color_led_blue_value`  out  8*C each  packed current values; LED n occupies bits [8n+7:8n]
- `o_basic_led_lumin_value`  out  8*B  packed current luminance values
- `o_busy`  out  1  high while any current value differs from its target
- `o_fade_done`  out  1  one-cycle pulse when a fade completes
- `o_cmd_error`  out  1  one-cycle pulse when a command index is out of range

## Operation
- **Per-channel state:** each of the NCH channels has `cur[7:0]`, `tgt[7:0]` and `step[7:0]`.
- **Tick counter:** counts down from TICK-1 to 0, then reloads. It raises an internal tick pulse at 0. It runs continuously out of reset, independent of the FSM.
- **FSM states:** IDLE and SCAN.
- **IDLE:**
  - `o_cmd_ready`=1.
  - A handshake (valid & ready) writes `tgt` and `step` for the addressed channels: 3 channels for a color LED, 1 for a basic LED.
  - If `i_cmd_step`=0, the handshake also writes `cur`=`tgt`.
  - If `i_cmd_index` ≥ C (color) or ≥ B (basic), the command is consumed, no state changes, and `o_cmd_error` pulses.
  - A tick, or a pending-tick flag, moves the FSM to SCAN with scan index k=0.
  - If a handshake and a tick occur in the same cycle, the command is written first and the scan starts on the next cycle.
- **SCAN:**
  - `o_cmd_ready`=0.
  - Processes one channel per cycle in this order: red 0..C-1, green 0..C-1, blue 0..C-1, basic 0..B-1.
  - After channel NCH-1 the FSM returns to IDLE.
  - A tick arriving during SCAN sets a pending flag. IDLE clears the flag when it launches the next scan. Ticks are never lost, but at most one tick is pending at a time.
- **Channel update rule (9-bit arithmetic, no wrap):**
  - If cur<tgt: cur = (cur+step ≥ tgt) ? tgt : cur+step.
  - If cur>tgt: cur = (cur−tgt ≤ step) ? tgt : cur−step.
  - If cur=tgt: no change.
  - A channel with step=0 and cur≠tgt cannot occur, because a step-0 command sets `cur` immediately.
- **`o_busy`:** registered; equals OR over all channels of (cur≠tgt).
- **`o_fade_done`:** pulses on the cycle after the last SCAN channel when at least one `cur` changed during that scan and all channels now equal their targets.

## Timing
- **Reset:** all `cur`, `tgt` and `step` = 0; all value buses = 0; `o_busy`, `o_fade_done`, `o_cmd_error`, `o_cmd_ready` = 0; tick counter = TICK-1; pending flag = 0; FSM = IDLE.
- **Ready after reset:** `o_cmd_ready` rises on the first cycle after `i_srst` deasserts.
- **Immediate set:** the output bus shows the new value on the cycle after the handshake edge.
- **`o_cmd_error`:** asserted on the cycle after the handshake edge.
- **Fade step:** channel k updates at edge tick+1+k, so it is visible on the output k+2 cycles after the tick cycle. A full scan lasts NCH cycles.
- **Reset mid-scan:** any cycle with `i_srst`=1 forces the reset values on the next edge, and any partial fade is discarded.
- **New command mid-fade:** a command accepted while a fade is in progress replaces `tgt` and `step`. Ramping continues from the current `cur`.

## Test plan
Run with parm_FCLK=100_000 and parm_step_period_milliseconds=1, giving TICK=100.

- **Reset:** hold `i_srst` 5 cycles, then release -> all buses 0, `o_busy`=0, `o_cmd_ready`=1 one cycle later, first tick 100 cycles later.
- **Immediate set:** command color idx 2, RGB=(0x12,0x34,0x56), step 0 -> bits [23:16] of the red/green/blue buses = 0x12/0x34/0x56 on the next cycle; `o_busy` stays 0.
- **Fade up:** color idx 0, red tgt 255, step 64 -> red[7:0] goes 64, 128, 192, 255 on four successive ticks; `o_busy` stays high until the value reaches 255; `o_fade_done` pulses exactly once, after the fourth scan.
- **Fade down with large step:** basic idx 3 set to 200 (step 0), then tgt 10 with step 250 -> lumin[31:24]=10 after one tick, with `o_fade_done` pulse.
- **Out-of-range command:** color idx 4 (C=4) -> command consumed, `o_cmd_error` pulses, no bus change.
- **Backpressure and reset mid-fade:**
  - Hold `i_cmd_valid` through a tick -> `o_cmd_ready` low for NCH=16 cycles, then the command is accepted.
  - Assert `i_srst` during SCAN -> all outputs 0 on the next cycle.
